// File: rtl/pe_channel_mac.sv
// Multi-channel convolution PE: per-beat KxK window multiply, registered adder tree,
// cross-channel accumulation with bias, then saturation and optional ReLU.
module pe_channel_mac #(
  parameter int PIC_BITS    = 8,
  parameter int WEIGHT_BITS = 8,
  parameter int KERNEL_SIZE = 5,
  parameter int CHANNELS    = 3,
  parameter int RESULT_BITS = 21,
  parameter int BIAS_BITS   = 21
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         clear,
  input  logic                         in_valid,
  input  logic [PIC_BITS-1:0]          pic    [KERNEL_SIZE*KERNEL_SIZE],
  input  logic [WEIGHT_BITS-1:0]       weight [KERNEL_SIZE*KERNEL_SIZE],
  input  logic [BIAS_BITS-1:0]         bias,
  input  logic                         signed_mode,
  input  logic                         relu_en,
  output logic [RESULT_BITS-1:0]       result,
  output logic                         result_valid,
  output logic                         sat,
  output logic [$clog2(CHANNELS):0]    chan_idx
);

  localparam int N   = KERNEL_SIZE * KERNEL_SIZE;
  localparam int PB  = PIC_BITS + WEIGHT_BITS;
  localparam int T   = $clog2(N);
  localparam int TW  = PB + T;
  localparam int CW  = $clog2(CHANNELS) + 1;
  localparam int ACC = TW + $clog2(CHANNELS) + 2;

  localparam logic signed [ACC-1:0] RES_MAX =
    {{(ACC-RESULT_BITS+1){1'b0}}, {(RESULT_BITS-1){1'b1}}};
  localparam logic signed [ACC-1:0] RES_MIN =
    {{(ACC-RESULT_BITS+1){1'b1}}, {(RESULT_BITS-1){1'b0}}};

  typedef struct packed {
    logic                 first;
    logic                 last;
    logic                 signed_mode;
    logic                 relu;
    logic [BIAS_BITS-1:0] bias;
  } beat_tag_t;

  function automatic int lvl_cnt(input int l);
    return (N + (1 << l) - 1) >> l;
  endfunction

  // ---------------- group tracking ----------------
  logic [CW-1:0] chan_idx_q, chan_idx_d;
  logic          grp_signed_q, grp_relu_q;
  logic          beat_first, beat_last, beat_signed, beat_relu;

  assign beat_first  = (chan_idx_q == '0);
  assign beat_last   = (chan_idx_q == CW'(CHANNELS - 1));
  assign beat_signed = beat_first ? signed_mode : grp_signed_q;
  assign beat_relu   = beat_first ? relu_en     : grp_relu_q;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    chan_idx_d = chan_idx_q;
    if (clear)         chan_idx_d = '0;
    else if (in_valid) chan_idx_d = beat_last ? '0 : chan_idx_q + CW'(1);
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chan_idx_q   <= '0;
      grp_signed_q <= 1'b0;
      grp_relu_q   <= 1'b0;
    end else begin
      chan_idx_q <= chan_idx_d;
      if (in_valid && !clear && beat_first) begin
        grp_signed_q <= signed_mode;
        grp_relu_q   <= relu_en;
      end
    end
  end

  // ---------------- multiply + adder tree ----------------
  // Index 0 of the valid/tag pipeline is the multiply stage, index T the tree root.
  logic [T:0]    vld_q, vld_d;
  beat_tag_t     tag_q [T+1];
  logic [TW-1:0] lvl_q [T+1][N];
  logic [TW-1:0] prod_ext [N];

  always_comb begin
    for (int i = 0; i < N; i++) begin
      if (beat_signed)
        prod_ext[i] = TW'($signed(PB'($signed(pic[i])) * PB'($signed(weight[i]))));
      else
        prod_ext[i] = TW'(PB'(pic[i]) * PB'(weight[i]));
    end
  end

  always_comb begin
    vld_d    = '0;
    vld_d[0] = in_valid;
    for (int i = 1; i <= T; i++) vld_d[i] = vld_q[i-1];
    if (clear) vld_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) vld_q <= '0;
    else        vld_q <= vld_d;
  end

  // NOTE: datapath and tag registers carry no reset; only the valid bits qualify them.
  // Tree nodes sit at the final tree width: modular adds stay exact because the true
  // window sum always fits TW bits under the mode carried by the beat.
  always_ff @(posedge clk) begin
    lvl_q[0] <= prod_ext;
    tag_q[0] <= '{first: beat_first, last: beat_last, signed_mode: beat_signed,
                  relu: beat_relu, bias: bias};
    for (int l = 1; l <= T; l++) begin
      tag_q[l] <= tag_q[l-1];
      for (int i = 0; i < N/2; i++)
        if (2*i + 1 < lvl_cnt(l-1))
          lvl_q[l][i] <= lvl_q[l-1][2*i] + lvl_q[l-1][2*i+1];
      if (lvl_cnt(l-1) % 2 == 1)
        lvl_q[l][lvl_cnt(l-1)/2] <= lvl_q[l-1][lvl_cnt(l-1)-1];
    end
  end

  // ---------------- accumulate ----------------
  beat_tag_t              root_tag;
  logic [ACC-1:0]         tree_ext, bias_ext;
  logic signed [ACC-1:0]  acc_q, acc_d;
  logic                   acc_done_q, acc_relu_q;

  assign root_tag = tag_q[T];
  assign tree_ext = root_tag.signed_mode ? ACC'($signed(lvl_q[T][0])) : ACC'(lvl_q[T][0]);
  assign bias_ext = ACC'($signed(root_tag.bias));
  assign acc_d    = root_tag.first ? $signed(tree_ext + bias_ext) : $signed(acc_q + tree_ext);

  always_ff @(posedge clk) begin
    if (vld_q[T]) begin
      acc_q      <= acc_d;
      acc_relu_q <= root_tag.relu;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     acc_done_q <= 1'b0;
    else if (clear) acc_done_q <= 1'b0;
    else            acc_done_q <= vld_q[T] & root_tag.last;
  end

  // ---------------- saturate / rectify / output ----------------
  logic                   pos_ovf, neg_ovf;
  logic [RESULT_BITS-1:0] result_d, result_q;
  logic                   sat_q, result_valid_q;

  always_comb begin
    pos_ovf  = (acc_q > RES_MAX);
    neg_ovf  = (acc_q < RES_MIN);
    result_d = acc_q[RESULT_BITS-1:0];
    if (pos_ovf) result_d = {1'b0, {(RESULT_BITS-1){1'b1}}};
    if (neg_ovf) result_d = {1'b1, {(RESULT_BITS-1){1'b0}}};
    if (acc_relu_q && acc_q[ACC-1]) result_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q       <= '0;
      sat_q          <= 1'b0;
      result_valid_q <= 1'b0;
    end else begin
      result_valid_q <= acc_done_q & ~clear;
      if (acc_done_q && !clear) begin
        result_q <= result_d;
        sat_q    <= pos_ovf | neg_ovf;
      end
    end
  end

  assign result       = result_q;
  assign sat          = sat_q;
  assign result_valid = result_valid_q;
  assign chan_idx     = chan_idx_q;

endmodule

// File: tb/tb_pe_channel_mac.sv
// Directed bench for pe_channel_mac: table of uniform-tap groups plus hand sequences
// for back-to-back groups, in_valid gaps, clear and mid-flight reset.
module tb_pe_channel_mac;

  localparam int N  = 25;
  localparam int RB = 21;

  logic          clk = 1'b0;
  logic          rst_n, clear, in_valid;
  logic [7:0]    pic [N];
  logic [7:0]    weight [N];
  logic [RB-1:0] bias;
  logic          signed_mode, relu_en;
  logic [RB-1:0] result;
  logic          result_valid, sat;
  logic [2:0]    chan_idx;

  int n_checks = 0;
  int n_pass   = 0;

  pe_channel_mac dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .clear        (clear),
    .in_valid     (in_valid),
    .pic          (pic),
    .weight       (weight),
    .bias         (bias),
    .signed_mode  (signed_mode),
    .relu_en      (relu_en),
    .result       (result),
    .result_valid (result_valid),
    .sat          (sat),
    .chan_idx     (chan_idx)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          sm;
    logic          relu;
    logic [7:0]    p;
    logic [7:0]    w;
    logic [RB-1:0] b;
    logic [RB-1:0] exp_res;
    logic          exp_sat;
  } vec_t;

  vec_t vecs [11];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", name, act, exp);
    else n_pass++;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One accepted beat with uniform taps; returns #1 after the sampling edge.
  task automatic beat(input logic [7:0] p, input logic [7:0] w, input logic [RB-1:0] b,
                      input logic sm, input logic relu);
    for (int i = 0; i < N; i++) begin
      pic[i]    = p;
      weight[i] = w;
    end
    bias        = b;
    signed_mode = sm;
    relu_en     = relu;
    in_valid    = 1'b1;
    step();
  endtask

  // Cycles from the last beat's edge until result_valid is seen; -1 if it never comes.
  task automatic wait_result(output int lat);
    lat = -1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (result_valid) begin
        lat = c;
        break;
      end
    end
  endtask

  task automatic count_pulses(input int cycles, output int pulses);
    pulses = 0;
    for (int c = 0; c < cycles; c++) begin
      step();
      if (result_valid) pulses++;
    end
  endtask

  initial begin
    int           lat, pulses, k;
    int           stamp [2];
    logic [RB-1:0] res_seen [2];
    logic [RB-1:0] held;

    vecs[0]  = '{1'b0, 1'b0, 8'd1,   8'd2,   21'd10,       21'd160,      1'b0};
    vecs[1]  = '{1'b1, 1'b0, 8'd1,   8'hFF,  21'd0,        21'h1FFFB5,   1'b0};
    vecs[2]  = '{1'b1, 1'b1, 8'd1,   8'hFF,  21'd0,        21'd0,        1'b0};
    vecs[3]  = '{1'b0, 1'b0, 8'd255, 8'd255, 21'd0,        21'd1048575,  1'b1};
    vecs[4]  = '{1'b1, 1'b0, 8'h80,  8'h80,  21'd0,        21'd1048575,  1'b1};
    vecs[5]  = '{1'b0, 1'b0, 8'd3,   8'd5,   21'h1FFF9C,   21'd1025,     1'b0};
    vecs[6]  = '{1'b1, 1'b0, 8'h80,  8'h7F,  21'd0,        21'h100000,   1'b1};
    vecs[7]  = '{1'b1, 1'b1, 8'h80,  8'h7F,  21'd0,        21'd0,        1'b1};
    vecs[8]  = '{1'b0, 1'b0, 8'd0,   8'd9,   21'h0FFFFF,   21'h0FFFFF,   1'b0};
    vecs[9]  = '{1'b1, 1'b0, 8'd0,   8'd0,   21'h100000,   21'h100000,   1'b0};
    vecs[10] = '{1'b1, 1'b1, 8'hFF,  8'd2,   21'd150,      21'd0,        1'b0};

    rst_n = 1'b0; clear = 1'b0; in_valid = 1'b0;
    bias = '0; signed_mode = 1'b0; relu_en = 1'b0;
    for (int i = 0; i < N; i++) begin
      pic[i]    = '0;
      weight[i] = '0;
    end
    #12;
    check("reset result", 32'(result), 32'd0);
    check("reset result_valid", 32'(result_valid), 32'd0);
    check("reset sat", 32'(sat), 32'd0);
    check("reset chan_idx", 32'(chan_idx), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    step();

    // ---- table-driven groups ----
    for (int v = 0; v < 11; v++) begin
      for (int b = 0; b < 3; b++)
        beat(vecs[v].p, vecs[v].w, vecs[v].b, vecs[v].sm, vecs[v].relu);
      in_valid = 1'b0;
      wait_result(lat);
      check($sformatf("vec%0d latency", v), 32'(lat), 32'd7);
      check($sformatf("vec%0d result", v), 32'(result), 32'(vecs[v].exp_res));
      check($sformatf("vec%0d sat", v), 32'(sat), 32'(vecs[v].exp_sat));
      step();
      check($sformatf("vec%0d pulse width", v), 32'(result_valid), 32'd0);
      check($sformatf("vec%0d result hold", v), 32'(result), 32'(vecs[v].exp_res));
    end

    // ---- gaps inside a group; chan_idx tracking ----
    beat(8'd4, 8'd4, 21'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    check("gap chan_idx after beat1", 32'(chan_idx), 32'd1);
    step(); step();
    check("gap chan_idx idle", 32'(chan_idx), 32'd1);
    check("gap no early result", 32'(result_valid), 32'd0);
    beat(8'd4, 8'd4, 21'd999, 1'b1, 1'b1);
    check("gap chan_idx after beat2", 32'(chan_idx), 32'd2);
    beat(8'd4, 8'd4, 21'd999, 1'b1, 1'b1);
    in_valid = 1'b0;
    check("gap chan_idx wrap", 32'(chan_idx), 32'd0);
    wait_result(lat);
    check("gap latency", 32'(lat), 32'd7);
    check("gap result", 32'(result), 32'd1200);

    // ---- back-to-back groups; signed_mode toggled on beat 2 of group 1 ----
    beat(8'd200, 8'd1, 21'd5,   1'b0, 1'b0);
    beat(8'd200, 8'd1, 21'd5,   1'b1, 1'b0);
    beat(8'd200, 8'd1, 21'd5,   1'b0, 1'b0);
    beat(8'd1,   8'd1, 21'd100, 1'b0, 1'b0);
    beat(8'd1,   8'd1, 21'd100, 1'b0, 1'b0);
    beat(8'd1,   8'd1, 21'd100, 1'b0, 1'b0);
    in_valid = 1'b0;
    k = 0;
    for (int c = 0; c < 20 && k < 2; c++) begin
      step();
      if (result_valid) begin
        stamp[k]    = c;
        res_seen[k] = result;
        k++;
      end
    end
    check("b2b pulse count", 32'(k), 32'd2);
    if (k == 2) begin
      check("b2b spacing", 32'(stamp[1] - stamp[0]), 32'd3);
      check("b2b group1 result", 32'(res_seen[0]), 32'd15005);
      check("b2b group2 result", 32'(res_seen[1]), 32'd175);
    end

    // ---- clear: completed group in flight plus partial group, both discarded ----
    beat(8'd1, 8'd1, 21'd7,    1'b0, 1'b0);
    beat(8'd1, 8'd1, 21'd7,    1'b0, 1'b0);
    beat(8'd1, 8'd1, 21'd7,    1'b0, 1'b0);
    beat(8'd1, 8'd1, 21'd1000, 1'b0, 1'b0);
    beat(8'd1, 8'd1, 21'd1000, 1'b0, 1'b0);
    clear = 1'b1;
    beat(8'd1, 8'd1, 21'd1000, 1'b0, 1'b0);
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear chan_idx", 32'(chan_idx), 32'd0);
    check("clear result_valid", 32'(result_valid), 32'd0);
    count_pulses(12, pulses);
    check("clear no stale results", 32'(pulses), 32'd0);
    for (int b = 0; b < 3; b++) beat(8'd2, 8'd1, 21'd0, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_result(lat);
    check("post-clear latency", 32'(lat), 32'd7);
    check("post-clear result", 32'(result), 32'd150);

    // ---- asynchronous reset with a group in flight ----
    for (int b = 0; b < 3; b++) beat(8'd3, 8'd3, 21'd1, 1'b0, 1'b0);
    beat(8'd3, 8'd3, 21'd1, 1'b0, 1'b0);
    in_valid = 1'b0;
    held = result;
    check("pre-reset result nonzero", 32'(held != '0), 32'd1);
    step();
    #3 rst_n = 1'b0;
    #1;
    check("async reset result", 32'(result), 32'd0);
    check("async reset sat", 32'(sat), 32'd0);
    check("async reset chan_idx", 32'(chan_idx), 32'd0);
    check("async reset result_valid", 32'(result_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    count_pulses(15, pulses);
    check("no result after reset", 32'(pulses), 32'd0);
    for (int b = 0; b < 3; b++) beat(vecs[0].p, vecs[0].w, vecs[0].b, 1'b0, 1'b0);
    in_valid = 1'b0;
    wait_result(lat);
    check("post-reset latency", 32'(lat), 32'd7);
    check("post-reset result", 32'(result), 32'd160);
    check("post-reset sat", 32'(sat), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/pe_channel_mac.md
# pe_channel_mac

Parametrised multi-channel convolution processing element for the CNN accelerator. It accepts one KERNEL_SIZE×KERNEL_SIZE window of pixels and weights per beat, one beat per input channel. It multiplies the operands in signed or unsigned mode and sums each window through a fully registered adder tree. Partial sums are accumulated across CHANNELS beats, and the block then adds a bias, applies saturation and optional ReLU, and emits one result per output pixel.

## Interface
- PIC_BITS, 8, pixel operand width
- WEIGHT_BITS, 8, weight operand width
- KERNEL_SIZE, 5, window side; N = KERNEL_SIZE*KERNEL_SIZE products per beat
- CHANNELS, 3, beats accumulated per result (≥1)
- RESULT_BITS, 21, two's-complement output width
- BIAS_BITS, 21, two's-complement bias width
- clk  in  1  single clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- clear  in  1  synchronous flush of group and pipeline
- in_valid  in  1  beat valid; the block accepts every beat (no backpressure)
- pic  in  [PIC_BITS-1:0] x N  window pixels, unpacked array
- weight  in  [WEIGHT_BITS-1:0] x N  window weights, unpacked array
- bias  in  BIAS_BITS  bias, sampled on first beat of a group
- signed_mode  in  1  1 = operands two's complement, 0 = unsigned; sampled on first beat
- relu_en  in  1  clamp negative results to 0; sampled on first beat
- result  out  RESULT_BITS  saturated, optionally rectified sum
- result_valid  out  1  one-cycle pulse per completed group
- sat  out  1  result was clamped; qualified by result_valid
- chan_idx  out  $clog2(CHANNELS)+1  index of the next beat expected within the group

## Operation
- Group counter chan_idx: increments on each accepted beat and wraps CHANNELS-1 → 0. A beat is *first* when chan_idx==0 and *last* when chan_idx==CHANNELS-1. With CHANNELS=1, every beat is both first and last.
- First beat latches signed_mode and relu_en for the group. Later beats ignore those pins.
- First/last flags, latched mode, relu_en and bias travel down the pipeline with the beat. This lets back-to-back groups overlap.
- Stage M (multiply) registers N products of PRODUCT_BITS = PIC_BITS+WEIGHT_BITS:
  - signed mode: operands are sign-extended;
  - unsigned mode: operands are zero-extended.
- Adder tree has T = $clog2(N) registered stages. Each stage adds pairs; an odd element passes through registered. Width grows by 1 per stage to PRODUCT_BITS+T.
- Accumulator width ACC = PRODUCT_BITS+T+$clog2(CHANNELS)+2, signed:
  - first beat: acc = tree_sum + sext(bias);
  - other beats: acc += tree_sum.
  - Tree sums are sign-extended in signed mode and zero-extended otherwise.
- On the last beat, the final value is computed in this order:
  1. Clamp to [-2^(RESULT_BITS-1), 2^(RESULT_BITS-1)-1]; sat=1 if clamped.
  2. If relu_en and the value is negative: result=0. sat keeps the clamp status.
- Pipeline valid bits shift every cycle. There is no stall.
- clear has the highest priority on the next edge:
  - chan_idx=0 and all pipeline valid bits = 0; any in_valid in the same cycle is dropped;
  - result_valid=0 from the next cycle;
  - the next accepted beat starts a fresh group;
  - data registers need not clear.
- Reset mid-operation: all state is discarded asynchronously and no partial result is emitted.

## Timing
- Reset values: result=0, result_valid=0, sat=0, chan_idx=0, all pipeline valid bits=0.
- Latency: last beat sampled at edge E, result_valid=1 for the cycle after edge E+T+2 (M stage + T tree stages + accumulate/output stage). This is 7 cycles at default parameters.
- Throughput: one beat per cycle, one result per CHANNELS cycles under continuous in_valid.
- result and sat hold their value until the next result_valid.
- in_valid gaps inside a group are allowed. The group completes only on its CHANNELS-th accepted beat.
- Mode pins changing mid-group have no effect until the next first beat.

## Test plan
- Unsigned, pic=1, weight=2 on all taps, bias=10, 3 beats → one result_valid 7 cycles after third beat, result=160, sat=0.
- Signed, pic=1, weight=8'hFF (-1), bias=0, 3 beats:
  - relu_en=0 → result=21'h1FFFB5 (-75), sat=0;
  - repeat with relu_en=1 → result=0.
- Unsigned, pic=weight=255, 3 beats → sum 4876875 clamps to result=1048575 with sat=1. Signed, pic=weight=-128 → clamps to 1048575 with sat=1.
- Six consecutive beats (two groups) with different biases → two result_valid pulses exactly 3 cycles apart, each result correct. signed_mode toggled on beat 2 has no effect on group 1.
- clear asserted after beat 2 of a group, then 3 new beats → no result for the aborted group; the next result equals the fresh 3-beat sum; chan_idx=0 after clear.
- rst_n low mid-group with results in flight → outputs 0 immediately, no result_valid after release. The first group after reset computes correctly.
